// File: rtl/rom_load_pkg.sv
// Shared types for the ROM download controller: FSM states,
// region indices and datapath widths.
package rom_load_pkg;

    localparam int ADDR_W    = 17;
    localparam int CNT_W     = 18;
    localparam int IO_ADDR_W = 25;
    localparam int NREG      = 4;

    localparam int REG_CPU  = 0;
    localparam int REG_GFX  = 1;
    localparam int REG_SND  = 2;
    localparam int REG_PROM = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

endpackage

// File: rtl/rom_load_ctrl_if.sv
// HPS ioctl download bus plus the ROM write port.
// master: download source / ROM sink; slave: rom_load_ctrl.
interface rom_load_ctrl_if;
    import rom_load_pkg::*;

    logic                 ioctl_download;
    logic                 ioctl_wr;
    logic [IO_ADDR_W-1:0] ioctl_addr;
    logic [7:0]           ioctl_dout;
    logic [ADDR_W-1:0]    rom_addr;
    logic [7:0]           rom_data;
    logic [NREG-1:0]      rom_we;

    modport master (
        output ioctl_download, ioctl_wr,
        output ioctl_addr, ioctl_dout,
        input  rom_addr, rom_data, rom_we
    );

    modport slave (
        input  ioctl_download, ioctl_wr,
        input  ioctl_addr, ioctl_dout,
        output rom_addr, rom_data, rom_we
    );

endinterface

// File: rtl/rom_region_dec.sv
// Combinational ROM region decoder.
// ioctl_addr in; one-hot sel, region-relative rel_addr, oob out.
module rom_region_dec
    import rom_load_pkg::*;
#(
    parameter logic [ADDR_W-1:0] CPU_END  = 17'h07FFF,
    parameter logic [ADDR_W-1:0] GFX_END  = 17'h0FFFF,
    parameter logic [ADDR_W-1:0] SND_END  = 17'h13FFF,
    parameter logic [ADDR_W-1:0] PROM_END = 17'h140FF
) (
    input  logic [IO_ADDR_W-1:0] ioctl_addr,
    output logic [NREG-1:0]      sel,
    output logic [ADDR_W-1:0]    rel_addr,
    output logic                 oob
);

    logic [ADDR_W-1:0] a;
    logic              hi;
    logic              in_cpu, in_gfx, in_snd, in_prom;

    assign a  = ioctl_addr[ADDR_W-1:0];
    assign hi = |ioctl_addr[IO_ADDR_W-1:ADDR_W];

    // Mutually exclusive windows so the decoder below is truly unique.
    assign in_cpu  = !hi && (a <= CPU_END);
    assign in_gfx  = !hi && (a > CPU_END) && (a <= GFX_END);
    assign in_snd  = !hi && (a > GFX_END) && (a <= SND_END);
    assign in_prom = !hi && (a > SND_END) && (a <= PROM_END);

    always_comb begin
        sel      = '0;
        rel_addr = '0;
        oob      = 1'b0;
        unique case (1'b1)
            in_cpu: begin
                sel[REG_CPU] = 1'b1;
                rel_addr     = a;
            end
            in_gfx: begin
                sel[REG_GFX] = 1'b1;
                rel_addr     = a - (CPU_END + 1'b1);
            end
            in_snd: begin
                sel[REG_SND] = 1'b1;
                rel_addr     = a - (GFX_END + 1'b1);
            end
            in_prom: begin
                sel[REG_PROM] = 1'b1;
                rel_addr      = a - (SND_END + 1'b1);
            end
            default: oob = 1'b1;
        endcase
    end

endmodule

// File: rtl/rom_load_ctrl.sv
// ROM download controller: routes HPS ioctl bytes to per-region ROM
// write ports and holds the game core in reset until the download has
// settled.
// Ports: clk_sys, reset_n (sync, active-low); bus (ioctl in, rom out);
// core_reset_n, loading, oob_err, byte_cnt; rom_sum when the
// ROM_CHECKSUM_EN macro is defined.
module rom_load_ctrl
    import rom_load_pkg::*;
#(
    parameter logic [ADDR_W-1:0] CPU_END    = 17'h07FFF,
    parameter logic [ADDR_W-1:0] GFX_END    = 17'h0FFFF,
    parameter logic [ADDR_W-1:0] SND_END    = 17'h13FFF,
    parameter logic [ADDR_W-1:0] PROM_END   = 17'h140FF,
    parameter int                SETTLE_CYC = 16
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    rom_load_ctrl_if.slave   bus,
    output logic             core_reset_n,
    output logic             loading,
    output logic             oob_err,
    output logic [CNT_W-1:0] byte_cnt
`ifdef ROM_CHECKSUM_EN
    ,
    output logic [7:0]       rom_sum
`endif
);

    localparam logic [7:0] SETTLE_LIM = 8'(SETTLE_CYC);

    state_t            state;
    logic [7:0]        settle_cnt;
    logic [NREG-1:0]   dec_sel;
    logic [ADDR_W-1:0] dec_rel;
    logic              dec_oob;
    logic              acc;
    logic              ld_entry;

    rom_region_dec #(
        .CPU_END  (CPU_END),
        .GFX_END  (GFX_END),
        .SND_END  (SND_END),
        .PROM_END (PROM_END)
    ) u_dec (
        .ioctl_addr (bus.ioctl_addr),
        .sel        (dec_sel),
        .rel_addr   (dec_rel),
        .oob        (dec_oob)
    );

    assign acc      = bus.ioctl_wr && bus.ioctl_download;
    // A write on the entry cycle counts toward the fresh download.
    assign ld_entry = bus.ioctl_download && (state != ST_LOAD);

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            settle_cnt   <= '0;
            bus.rom_we   <= '0;
            bus.rom_addr <= '0;
            bus.rom_data <= '0;
            core_reset_n <= 1'b0;
            loading      <= 1'b0;
            oob_err      <= 1'b0;
            byte_cnt     <= '0;
`ifdef ROM_CHECKSUM_EN
            rom_sum      <= '0;
`endif
        end else begin
            bus.rom_we <= '0;
            if (acc) begin
                bus.rom_addr <= dec_rel;
                bus.rom_data <= bus.ioctl_dout;
                if (!dec_oob) bus.rom_we <= dec_sel;
            end

            unique case (state)
                ST_IDLE, ST_RUN: begin
                    if (bus.ioctl_download) begin
                        state        <= ST_LOAD;
                        loading      <= 1'b1;
                        core_reset_n <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (!bus.ioctl_download) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (bus.ioctl_download) begin
                        state      <= ST_LOAD;
                        settle_cnt <= '0;
                    end else if (settle_cnt == SETTLE_LIM) begin
                        state        <= ST_RUN;
                        loading      <= 1'b0;
                        core_reset_n <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (ld_entry) begin
                oob_err  <= acc && dec_oob;
                byte_cnt <= (acc && !dec_oob) ? CNT_W'(1) : '0;
`ifdef ROM_CHECKSUM_EN
                rom_sum  <= (acc && !dec_oob) ? bus.ioctl_dout : 8'd0;
`endif
            end else if (acc) begin
                if (dec_oob) begin
                    oob_err <= 1'b1;
                end else begin
                    if (byte_cnt != '1) byte_cnt <= byte_cnt + 1'b1;
`ifdef ROM_CHECKSUM_EN
                    rom_sum <= rom_sum + bus.ioctl_dout;
`endif
                end
            end
        end
    end

endmodule
